// File: rtl/param_voting_machine.sv
// N-candidate ballot unit: officer-armed single-vote capture with lockout, invalid-press
// rejection, saturating per-candidate counters and a sequential winner/tie tally.
module param_voting_machine #(
   parameter int NUM_CAND    = 4,
   parameter int CNT_W       = 8,
   parameter int LOCKOUT_CYC = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_ballot_en,
   input  logic [NUM_CAND-1:0]                i_candidate,
   input  logic                               i_voting_over,
   output logic                               o_ready,
   output logic                               o_vote_ack,
   output logic                               o_invalid,
   output logic                               o_sat,
   output logic [NUM_CAND*CNT_W-1:0]          o_counts,
   output logic [CNT_W+$clog2(NUM_CAND)-1:0]  o_total,
   output logic [$clog2(NUM_CAND)-1:0]        o_winner,
   output logic                               o_tie,
   output logic                               o_results_valid
);

   localparam int IDX_W = $clog2(NUM_CAND);
   localparam int TOT_W = CNT_W + IDX_W;
   localparam int LCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_LOCKOUT,
      S_TALLY,
      S_RESULT
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;

   logic [NUM_CAND-1:0]       r_prev;
   logic [NUM_CAND-1:0]       w_press;
   logic                      w_one_press;
   logic                      w_multi_press;
   logic [IDX_W-1:0]          w_press_idx;
   logic                      w_accept;
   logic                      w_reject;
   logic                      w_lock_done;
   logic                      w_scan_last;
   logic [LCK_W-1:0]          r_lock_cnt;
   logic [IDX_W-1:0]          r_scan_idx;
   logic                      r_vote_ack;
   logic                      r_invalid;
   logic                      r_sat;
   logic [TOT_W-1:0]          r_total;
   logic [CNT_W-1:0]          r_max;
   logic [IDX_W-1:0]          r_winner;
   logic                      r_tie;
   logic [CNT_W-1:0]          w_cur;
   logic [NUM_CAND*CNT_W-1:0] w_counts;
   logic [NUM_CAND-1:0]       w_sat_hit;

   // A press is a rising edge; the history resets to all-ones so held buttons never count.
   assign w_press       = i_candidate & ~r_prev;
   assign w_multi_press = |(w_press & (w_press - NUM_CAND'(1)));
   assign w_one_press   = (|w_press) & ~w_multi_press;
   assign w_lock_done   = (r_lock_cnt == LCK_W'(LOCKOUT_CYC - 1));
   assign w_scan_last   = (r_scan_idx == IDX_W'(NUM_CAND - 1));

   always_comb begin
      w_press_idx = '0;
      for (int k = 0; k < NUM_CAND; k++) begin
         if (w_press[k]) w_press_idx = IDX_W'(k);
      end
   end

   always_comb begin
      w_cur = '0;
      for (int k = 0; k < NUM_CAND; k++) begin
         if (r_scan_idx == IDX_W'(k)) w_cur = w_counts[k*CNT_W +: CNT_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state    = r_state;
      w_accept        = 1'b0;
      w_reject        = 1'b0;
      o_ready         = 1'b0;
      o_results_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_voting_over)    w_next_state = S_TALLY;
            else if (i_ballot_en) w_next_state = S_ARMED;
         end
         S_ARMED: begin
            o_ready = 1'b1;
            if (i_voting_over) begin
               w_next_state = S_TALLY;
            end else if (w_one_press) begin
               w_accept     = 1'b1;
               w_next_state = S_LOCKOUT;
            end else if (w_multi_press) begin
               w_reject = 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (i_voting_over)    w_next_state = S_TALLY;
            else if (w_lock_done) w_next_state = S_IDLE;
         end
         S_TALLY: begin
            if (w_scan_last) w_next_state = S_RESULT;
         end
         S_RESULT: begin
            o_results_valid = 1'b1;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev     <= '1;
         r_lock_cnt <= '0;
         r_scan_idx <= '0;
         r_vote_ack <= 1'b0;
         r_invalid  <= 1'b0;
      end else begin
         r_prev     <= i_candidate;
         r_vote_ack <= w_accept;
         r_invalid  <= w_reject;
         if (r_state == S_LOCKOUT) r_lock_cnt <= r_lock_cnt + LCK_W'(1);
         else                      r_lock_cnt <= '0;
         if (r_state != S_TALLY)   r_scan_idx <= '0;
         else if (!w_scan_last)    r_scan_idx <= r_scan_idx + IDX_W'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CAND; gi++) begin : g_cand
         logic             w_hit;
         logic [CNT_W-1:0] r_cnt;

         assign w_hit         = w_accept && (w_press_idx == IDX_W'(gi));
         assign w_sat_hit[gi] = w_hit && (r_cnt == '1);
         assign w_counts[gi*CNT_W +: CNT_W] = r_cnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)                         r_cnt <= '0;
            else if (w_hit && r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_total <= '0;
         r_sat   <= 1'b0;
      end else if (w_accept) begin
         if (r_total != '1) r_total <= r_total + TOT_W'(1);
         if (|w_sat_hit)    r_sat   <= 1'b1;
      end
   end

   // Strict '>' keeps the lowest index on ties; an equal later value only raises o_tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_max    <= '0;
         r_winner <= '0;
         r_tie    <= 1'b0;
      end else if (r_state == S_TALLY) begin
         if (r_scan_idx == '0) begin
            r_max    <= w_cur;
            r_winner <= '0;
            r_tie    <= 1'b0;
         end else if (w_cur > r_max) begin
            r_max    <= w_cur;
            r_winner <= r_scan_idx;
            r_tie    <= 1'b0;
         end else if (w_cur == r_max) begin
            r_tie    <= 1'b1;
         end
      end
   end

   assign o_vote_ack = r_vote_ack;
   assign o_invalid  = r_invalid;
   assign o_sat      = r_sat;
   assign o_counts   = w_counts;
   assign o_total    = r_total;
   assign o_winner   = r_winner;
   assign o_tie      = r_tie;

endmodule

// File: tb/tb_param_voting_machine.sv
// Scoreboarded random/directed bench for param_voting_machine with a behavioural
// ballot model; a monitor pops expectations on ack, invalid and results events.
module tb_param_voting_machine;

   localparam int NC   = 4;
   localparam int CW   = 3;
   localparam int LK   = 5;
   localparam int IW   = $clog2(NC);
   localparam int TW   = CW + IW;
   localparam int CMAX = (1 << CW) - 1;
   localparam int TMAX = (1 << TW) - 1;

   localparam int K_ACK = 1;
   localparam int K_INV = 2;
   localparam int K_RES = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                i_ballot_en = 1'b0;
   logic [NC-1:0]       i_candidate = '0;
   logic                i_voting_over = 1'b0;
   logic                o_ready, o_vote_ack, o_invalid, o_sat, o_tie, o_results_valid;
   logic [NC*CW-1:0]    o_counts;
   logic [TW-1:0]       o_total;
   logic [IW-1:0]       o_winner;

   param_voting_machine #(.NUM_CAND(NC), .CNT_W(CW), .LOCKOUT_CYC(LK)) dut (
      .clk(clk), .rst(rst), .i_ballot_en(i_ballot_en), .i_candidate(i_candidate),
      .i_voting_over(i_voting_over), .o_ready(o_ready), .o_vote_ack(o_vote_ack),
      .o_invalid(o_invalid), .o_sat(o_sat), .o_counts(o_counts), .o_total(o_total),
      .o_winner(o_winner), .o_tie(o_tie), .o_results_valid(o_results_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            kind;
      logic [NC*CW-1:0] counts;
      logic [TW-1:0] total;
      logic          sat;
      logic [IW-1:0] winner;
      logic          tie;
   } exp_t;

   exp_t sb_q[$];
   int   m_cnt[NC];
   int   m_total;
   bit   m_sat;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_ack_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic logic [NC*CW-1:0] model_counts();
      logic [NC*CW-1:0] r;
      r = '0;
      for (int k = 0; k < NC; k++) r[k*CW +: CW] = CW'(m_cnt[k]);
      return r;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NC; k++) m_cnt[k] = 0;
      m_total = 0;
      m_sat   = 1'b0;
      sb_q.delete();
   endfunction

   // Applies the ballot rules to a press mask seen while armed; returns 1 if accepted.
   function automatic bit model_vote(input logic [NC-1:0] mask);
      exp_t e;
      int   idx;
      idx = 0;
      e = '{kind: K_INV, counts: '0, total: '0, sat: 1'b0, winner: '0, tie: 1'b0};
      if ($countones(mask) == 1) begin
         for (int j = 0; j < NC; j++) if (mask[j]) idx = j;
         if (m_cnt[idx] == CMAX) m_sat = 1'b1;
         else                    m_cnt[idx]++;
         if (m_total < TMAX) m_total++;
         e.kind = K_ACK;
      end
      e.counts = model_counts();
      e.total  = TW'(m_total);
      e.sat    = m_sat;
      sb_q.push_back(e);
      return (e.kind == K_ACK);
   endfunction

   function automatic void model_tally();
      exp_t e;
      int   mx, w, nmax;
      mx = -1; w = 0; nmax = 0;
      for (int k = 0; k < NC; k++) if (m_cnt[k] > mx) begin mx = m_cnt[k]; w = k; end
      for (int k = 0; k < NC; k++) if (m_cnt[k] == mx) nmax++;
      e = '{kind: K_RES, counts: model_counts(), total: TW'(m_total), sat: m_sat,
            winner: IW'(w), tie: (nmax > 1)};
      sb_q.push_back(e);
   endfunction

   task automatic pop_check(input int kind);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_nonempty", 64'(sb_q.size()), 64'd1);
         return;
      end
      e = sb_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("ev_counts", 64'(o_counts), 64'(e.counts));
      check("ev_total", 64'(o_total), 64'(e.total));
      check("ev_sat", 64'(o_sat), 64'(e.sat));
      if (kind == K_RES) begin
         check("res_winner", 64'(o_winner), 64'(e.winner));
         check("res_tie", 64'(o_tie), 64'(e.tie));
      end
   endtask

   initial begin : monitor
      bit prev_rv;
      prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_rv = 1'b0;
         end else begin
            if (o_vote_ack) begin
               n_ack_seen++;
               $display("[%0t] ack     counts=%h total=%0d sat=%0b", $time, o_counts, o_total, o_sat);
               pop_check(K_ACK);
            end
            if (o_invalid) begin
               $display("[%0t] invalid counts=%h total=%0d", $time, o_counts, o_total);
               pop_check(K_INV);
            end
            if (o_results_valid && !prev_rv) begin
               $display("[%0t] result  winner=%0d tie=%0b counts=%h total=%0d",
                        $time, o_winner, o_tie, o_counts, o_total);
               pop_check(K_RES);
            end
            prev_rv = o_results_valid;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [NC-1:0] hold);
      i_candidate   = hold;
      i_ballot_en   = 1'b0;
      i_voting_over = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_outputs", 64'({o_ready, o_vote_ack, o_invalid, o_sat, o_counts, o_total,
                                o_winner, o_tie, o_results_valid}), 64'd0);
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic arm();
      i_ballot_en = 1'b1;
      tick();
      i_ballot_en = 1'b0;
      check("ready_after_arm", 64'(o_ready), 64'd1);
   endtask

   // Press then release; an accepted vote waits out the lockout back to IDLE.
   task automatic press(input logic [NC-1:0] mask, output bit accepted);
      accepted = model_vote(mask);
      i_candidate = mask;
      tick();
      i_candidate = '0;
      tick();
      if (accepted) repeat (LK) tick();
      else check("ready_after_invalid", 64'(o_ready), 64'd1);
   endtask

   task automatic cast_vote(input int k);
      logic [NC-1:0] m;
      bit acc;
      m = '0;
      m[k] = 1'b1;
      arm();
      press(m, acc);
   endtask

   task automatic tally();
      model_tally();
      i_voting_over = 1'b1;
      tick();
      i_voting_over = 1'b0;
      repeat (NC - 1) tick();
      check("rv_not_early", 64'(o_results_valid), 64'd0);
      tick();
      check("rv_on_time", 64'(o_results_valid), 64'd1);
      tick();
   endtask

   task automatic votes_for(input int v0, input int v1, input int v2, input int v3);
      int v[NC];
      v = '{v0, v1, v2, v3};
      for (int k = 0; k < NC; k++) repeat (v[k]) cast_vote(k);
   endtask

   initial begin : stim
      bit acc;
      int a0;
      logic [NC-1:0] m;
      int b1, b2;

      // T1: two votes for candidate 2
      do_reset('0);
      a0 = n_ack_seen;
      cast_vote(2);
      cast_vote(2);
      check("t1_count2", 64'(o_counts[2*CW +: CW]), 64'd2);
      check("t1_total", 64'(o_total), 64'd2);
      check("t1_acks", 64'(n_ack_seen - a0), 64'd2);

      // T2: simultaneous presses rejected, then a single press counts
      arm();
      press(4'b1001, acc);
      press(4'b1000, acc);
      check("t2_count3", 64'(o_counts[3*CW +: CW]), 64'd1);

      // T3: held/re-pressed buttons during lockout and presses in IDLE are ignored
      arm();
      acc = model_vote(4'b0001);
      i_candidate = 4'b0001;
      tick();
      tick();
      i_candidate = '0;
      tick();
      i_candidate = 4'b0100;
      tick();
      i_candidate = '0;
      repeat (LK) tick();
      i_candidate = 4'b0010;
      tick();
      i_candidate = '0;
      tick();
      check("t3_counts", 64'(o_counts), 64'(model_counts()));
      check("t3_idle_ready", 64'(o_ready), 64'd0);

      // T6: reset mid-LOCKOUT, mid-TALLY, and with a button held through release
      arm();
      acc = model_vote(4'b0001);
      i_candidate = 4'b0001;
      tick();
      i_candidate = '0;
      tick();
      do_reset('0);
      cast_vote(1);
      i_voting_over = 1'b1;
      tick();
      i_voting_over = 1'b0;
      tick();
      do_reset(4'b0100);
      arm();
      tick();
      tick();
      i_candidate = '0;
      tick();
      check("t6_held_counts", 64'(o_counts), 64'd0);
      check("t6_held_ready", 64'(o_ready), 64'd1);

      // T4: saturation of candidate 1
      do_reset('0);
      a0 = n_ack_seen;
      repeat (9) cast_vote(1);
      check("t4_count1", 64'(o_counts[1*CW +: CW]), 64'd7);
      check("t4_sat", 64'(o_sat), 64'd1);
      check("t4_total", 64'(o_total), 64'd9);
      check("t4_acks", 64'(n_ack_seen - a0), 64'd9);

      // T5: tie, strict winner, empty poll; RESULT ignores further input
      do_reset('0);
      votes_for(3, 5, 5, 1);
      tally();
      check("t5a_winner", 64'(o_winner), 64'd1);
      check("t5a_tie", 64'(o_tie), 64'd1);
      i_ballot_en = 1'b1;
      tick();
      i_ballot_en = 1'b0;
      i_candidate = 4'b0001;
      tick();
      i_candidate = '0;
      tick();
      check("t5_result_frozen", 64'(o_counts), 64'(model_counts()));
      check("t5_result_held", 64'(o_results_valid), 64'd1);

      do_reset('0);
      votes_for(2, 6, 5, 1);
      tally();
      check("t5b_winner", 64'(o_winner), 64'd1);
      check("t5b_tie", 64'(o_tie), 64'd0);

      do_reset('0);
      tally();
      check("t5c_winner", 64'(o_winner), 64'd0);
      check("t5c_tie", 64'(o_tie), 64'd1);

      // Random ballots, occasionally with double presses
      do_reset('0);
      for (int i = 0; i < 40; i++) begin
         arm();
         if ($urandom_range(0, 3) == 0) begin
            b1 = $urandom_range(0, NC - 1);
            b2 = (b1 + $urandom_range(1, NC - 1)) % NC;
            m = '0;
            m[b1] = 1'b1;
            m[b2] = 1'b1;
            press(m, acc);
         end
         m = '0;
         m[$urandom_range(0, NC - 1)] = 1'b1;
         press(m, acc);
      end
      tally();

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

endmodule
